// File: rtl/sdram_arb_pkg.sv
// Shared types and the round-robin pick used by the two-port SDRAM arbiter.
package sdram_arb_pkg;

  localparam int NUM_REQ = 2;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    BUSY = 1'b1
  } arb_state_t;

  typedef logic [0:0] owner_t;

  // With both requesters eligible, the one that did not win last time goes next.
  function automatic owner_t rr_pick(input logic [NUM_REQ-1:0] elig, input owner_t last_grant);
    if (elig == 2'b11) return ~last_grant;
    else if (elig[1]) return 1'b1;
    else return 1'b0;
  endfunction

endpackage

// File: rtl/owner_fifo.sv
// Small FIFO recording which requester issued each outstanding read.
// Push and pop in the same cycle are accepted even when full.
module owner_fifo #(
  parameter int DEPTH = 8,
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW + 1)'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW:0]      count;
  logic             do_push;
  logic             do_pop;

  assign empty   = (count == '0);
  assign full    = (count == FULL_CNT);
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);
  assign dout    = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/sdram_port_arbiter.sv
// Two-requester round-robin arbiter onto one Avalon-MM SDRAM master port,
// routing read beats back by owner. Optional counters: define ARB_PERF_CNT_EN.
//
// state | meaning
// IDLE  | no command driven; arbitrate among eligible requesters
// BUSY  | granted command held on m_*, waiting for m_waitrequest low
module sdram_port_arbiter
  import sdram_arb_pkg::*;
#(
  parameter int ADDR_W   = 32,
  parameter int DATA_W   = 32,
  parameter int MAX_PEND = 8
) (
  input  logic                clk,
  input  logic                rst_n,

  input  logic [ADDR_W-1:0]   s0_address,
  input  logic                s0_read,
  input  logic                s0_write,
  input  logic [DATA_W-1:0]   s0_writedata,
  input  logic [DATA_W/8-1:0] s0_byteenable,
  output logic                s0_waitrequest,
  output logic [DATA_W-1:0]   s0_readdata,
  output logic                s0_readdatavalid,

  input  logic [ADDR_W-1:0]   s1_address,
  input  logic                s1_read,
  input  logic                s1_write,
  input  logic [DATA_W-1:0]   s1_writedata,
  input  logic [DATA_W/8-1:0] s1_byteenable,
  output logic                s1_waitrequest,
  output logic [DATA_W-1:0]   s1_readdata,
  output logic                s1_readdatavalid,

  output logic [ADDR_W-1:0]   m_address,
  output logic                m_read,
  output logic                m_write,
  output logic [DATA_W-1:0]   m_writedata,
  output logic [DATA_W/8-1:0] m_byteenable,
  input  logic                m_waitrequest,
  input  logic [DATA_W-1:0]   m_readdata,
  input  logic                m_readdatavalid,

`ifdef ARB_PERF_CNT_EN
  output logic [31:0]         perf_grant0,
  output logic [31:0]         perf_grant1,
  output logic [31:0]         perf_stall,
`endif
  output logic                err_rdv
);

  localparam logic [0:0] ST_IDLE = IDLE;
  localparam logic [0:0] ST_BUSY = BUSY;

  logic [0:0]         state;
  owner_t             owner;
  owner_t             last_grant;
  owner_t             gnt;
  owner_t             head;
  logic [NUM_REQ-1:0] elig;
  logic               fifo_full;
  logic               fifo_empty;
  logic               accept;
  logic               push;
  logic               rdv_hit;

  // A read may only be granted if there is room to remember its owner.
  assign elig[0] = s0_write | (s0_read & ~fifo_full);
  assign elig[1] = s1_write | (s1_read & ~fifo_full);
  assign gnt     = rr_pick(elig, last_grant);

  assign accept  = (state == ST_BUSY) & ~m_waitrequest;
  assign push    = accept & m_read;
  assign rdv_hit = m_readdatavalid & ~fifo_empty;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= ST_IDLE;
      owner        <= 1'b0;
      last_grant   <= 1'b1;
      m_address    <= '0;
      m_read       <= 1'b0;
      m_write      <= 1'b0;
      m_writedata  <= '0;
      m_byteenable <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (|elig) begin
            owner        <= gnt;
            state        <= ST_BUSY;
            m_address    <= gnt[0] ? s1_address    : s0_address;
            m_read       <= gnt[0] ? s1_read       : s0_read;
            m_write      <= gnt[0] ? s1_write      : s0_write;
            m_writedata  <= gnt[0] ? s1_writedata  : s0_writedata;
            m_byteenable <= gnt[0] ? s1_byteenable : s0_byteenable;
          end
        end
        ST_BUSY: begin
          if (!m_waitrequest) begin
            m_read     <= 1'b0;
            m_write    <= 1'b0;
            last_grant <= owner;
            state      <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  always_comb begin
    s0_waitrequest = 1'b1;
    s1_waitrequest = 1'b1;
    if (state == ST_BUSY) begin
      if (owner == 1'b0) s0_waitrequest = m_waitrequest;
      else               s1_waitrequest = m_waitrequest;
    end
  end

  owner_fifo #(
    .DEPTH (MAX_PEND),
    .WIDTH (1)
  ) u_owner_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (push),
    .pop   (rdv_hit),
    .din   (owner),
    .dout  (head),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  always_comb begin
    s0_readdatavalid = 1'b0;
    s1_readdatavalid = 1'b0;
    s0_readdata      = '0;
    s1_readdata      = '0;
    if (rdv_hit) begin
      if (head == 1'b0) begin
        s0_readdatavalid = 1'b1;
        s0_readdata      = m_readdata;
      end else begin
        s1_readdatavalid = 1'b1;
        s1_readdata      = m_readdata;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                               err_rdv <= 1'b0;
    else if (m_readdatavalid && fifo_empty)   err_rdv <= 1'b1;
  end

`ifdef ARB_PERF_CNT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      perf_grant0 <= '0;
      perf_grant1 <= '0;
      perf_stall  <= '0;
    end else begin
      if (accept && owner == 1'b0 && perf_grant0 != '1) perf_grant0 <= perf_grant0 + 1'b1;
      if (accept && owner == 1'b1 && perf_grant1 != '1) perf_grant1 <= perf_grant1 + 1'b1;
      if (state == ST_BUSY && m_waitrequest && perf_stall != '1) perf_stall <= perf_stall + 1'b1;
    end
  end
`endif

endmodule
